prog_delay_line: RTL and testbench

//  Multi-channel programmable sample delay for the ADC data path. Each channel is delayed by
//  a runtime-loadable number of sample strobes (1..DEPTH) using a circular buffer.

---
 rtl/prog_delay_line_pkg.sv | 29 ++
 rtl/dl_ring_ram.sv | 27 ++
 rtl/prog_delay_line.sv | 111 +++++++++++
 tb/tb_prog_delay_line.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_delay_line_pkg.sv
// Shared defaults, delay-width helper, delay clamp and strobe-op encoding
// for the programmable delay line.
package prog_delay_line_pkg;

    localparam int W_DEF        = 14;
    localparam int CH_DEF       = 2;
    localparam int DEPTH_DEF    = 32;
    localparam int INIT_DLY_DEF = 5;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_STROBE,
        OP_FLUSH
    } op_e;

    // One extra bit so that a delay of exactly DEPTH is representable.
    function automatic int dly_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned val, input int unsigned depth);
        if (val < 1)
            return 1;
        else if (val > depth)
            return depth;
        return val;
    endfunction

endpackage

// File: rtl/dl_ring_ram.sv
// Circular sample store: one synchronous write port, one asynchronous read port,
// so a read in the write cycle returns the old contents (read-first).
module dl_ring_ram #(
    parameter  int DW    = 28,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the fill counter instead,
    // which keeps this mappable onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable sample delay: shared write pointer, fill counter and
// delay register around a read-first ring RAM, with a registered output stage.
module prog_delay_line
    import prog_delay_line_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CH       = CH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DLY_W    = dly_width(DEPTH),
    parameter int INIT_DLY = INIT_DLY_DEF,
    parameter int BLANK    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [CH*W-1:0]   data_in,
    input  logic              delay_load,
    input  logic [DLY_W-1:0]  delay_val,
    input  logic              flush,
    output logic [CH*W-1:0]   data_out,
    output logic              out_valid,
    output logic [DLY_W-1:0]  cur_delay,
    output logic              delay_clamped
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = CH * W;

    logic [AW-1:0]    r_wr_ptr;
    logic [DLY_W-1:0] r_fill;
    logic [DLY_W-1:0] r_cur_delay;
    logic             r_clamped;
    logic             r_out_valid;
    logic [DW-1:0]    r_data_out;

    logic [DLY_W-1:0] w_load_dly;
    logic [DLY_W-1:0] w_eff_dly;
    logic [AW-1:0]    w_rd_addr;
    logic [DW-1:0]    w_rd_data;
    logic             w_fill_ok;
    op_e              w_op;

    assign w_load_dly = DLY_W'(clamp_delay(32'(delay_val), DEPTH));
    // A load in the same cycle as a strobe steers that strobe's read.
    assign w_eff_dly  = delay_load ? w_load_dly : r_cur_delay;
    // D == DEPTH wraps to the write slot itself; the read-first RAM returns the old sample.
    assign w_rd_addr  = r_wr_ptr - w_eff_dly[AW-1:0];
    assign w_fill_ok  = (r_fill >= w_eff_dly);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_op = OP_IDLE;
        if (flush)
            w_op = OP_FLUSH;
        else if (en)
            w_op = OP_STROBE;
    end

    dl_ring_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_op == OP_STROBE),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // NOTE: all state updates use non-blocking assignments so every register sees
    // pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_cur_delay <= DLY_W'(INIT_DLY);
            r_clamped   <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            if (delay_load) begin
                r_cur_delay <= w_load_dly;
                r_clamped   <= (w_load_dly != delay_val);
            end
            case (w_op)
                OP_FLUSH: begin
                    r_wr_ptr    <= '0;
                    r_fill      <= '0;
                    r_out_valid <= 1'b0;
                    if (BLANK != 0)
                        r_data_out <= '0;
                end
                OP_STROBE: begin
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    if (r_fill != DLY_W'(DEPTH))
                        r_fill <= r_fill + 1'b1;
                    r_out_valid <= w_fill_ok;
                    r_data_out  <= (BLANK != 0 && !w_fill_ok) ? '0 : w_rd_data;
                end
                default: ;
            endcase
        end
    end

    assign data_out      = r_data_out;
    assign out_valid     = r_out_valid;
    assign cur_delay     = r_cur_delay;
    assign delay_clamped = r_clamped;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench: queue-based history model compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_prog_delay_line;

    localparam int W        = 14;
    localparam int CH       = 2;
    localparam int DEPTH    = 32;
    localparam int DLY_W    = 6;
    localparam int INIT_DLY = 5;
    localparam int BLANK    = 1;
    localparam int DW       = CH * W;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             en = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic             delay_load = 1'b0;
    logic [DLY_W-1:0] delay_val = '0;
    logic             flush = 1'b0;
    logic [DW-1:0]    data_out;
    logic             out_valid;
    logic [DLY_W-1:0] cur_delay;
    logic             delay_clamped;

    int n_tests = 0;
    int n_fail  = 0;
    int samp    = 0;

    prog_delay_line #(
        .W        (W),
        .CH       (CH),
        .DEPTH    (DEPTH),
        .DLY_W    (DLY_W),
        .INIT_DLY (INIT_DLY),
        .BLANK    (BLANK)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .en            (en),
        .data_in       (data_in),
        .delay_load    (delay_load),
        .delay_val     (delay_val),
        .flush         (flush),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .cur_delay     (cur_delay),
        .delay_clamped (delay_clamped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int s);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'(s);
        b = W'(s * 3 + 7);
        return {b, a};
    endfunction

    function automatic int clamp(input int v);
        if (v < 1) return 1;
        if (v > DEPTH) return DEPTH;
        return v;
    endfunction

    // Model: the output of a strobe is the sample written D strobes earlier,
    // provided at least D samples have been written since reset/flush.
    logic [DW-1:0] hist[$];
    int            m_delay   = INIT_DLY;
    bit            m_clamped = 1'b0;
    bit            m_valid   = 1'b0;
    logic [DW-1:0] m_dout    = '0;
    int            m_c;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist.delete();
            m_delay   = INIT_DLY;
            m_clamped = 1'b0;
            m_valid   = 1'b0;
            m_dout    = '0;
        end else begin
            if (delay_load) begin
                m_c       = clamp(int'(delay_val));
                m_clamped = (m_c != int'(delay_val));
                m_delay   = m_c;
            end
            if (flush) begin
                hist.delete();
                m_valid = 1'b0;
                m_dout  = '0;
            end else if (en) begin
                m_valid = (hist.size() >= m_delay);
                m_dout  = m_valid ? hist[hist.size() - m_delay] : '0;
                hist.push_back(data_in);
                if (hist.size() > DEPTH)
                    void'(hist.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("model data_out",  64'(data_out),      64'(m_dout));
        check("model out_valid", 64'(out_valid),     64'(m_valid));
        check("model cur_delay", 64'(cur_delay),     64'(m_delay));
        check("model clamped",   64'(delay_clamped), 64'(m_clamped));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        repeat (n) begin
            samp++;
            data_in = pack(samp);
            en      = 1'b1;
            tick();
        end
        en = 1'b0;
    endtask

    task automatic load(input int v, input bit with_strobe);
        delay_val  = DLY_W'(v);
        delay_load = 1'b1;
        if (with_strobe) begin
            samp++;
            data_in = pack(samp);
            en      = 1'b1;
        end
        tick();
        delay_load = 1'b0;
        en         = 1'b0;
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset data_out",  64'(data_out),      64'd0);
        check("reset out_valid", 64'(out_valid),     64'd0);
        check("reset cur_delay", 64'(cur_delay),     64'd5);
        check("reset clamped",   64'(delay_clamped), 64'd0);
        rstn = 1'b1;
        tick();

        // Initial delay of 5: valid from the 6th strobe.
        strobe(5);
        check("t1 valid after 5", 64'(out_valid), 64'd0);
        strobe(1);
        check("t1 valid after 6", 64'(out_valid), 64'd1);
        check("t1 ch0 after 6",   64'(data_out[W-1:0]), 64'd1);
        check("t1 ch1 after 6",   64'(data_out[DW-1:W]), 64'd10);
        strobe(34);
        check("t1 ch0 after 40",  64'(data_out[W-1:0]), 64'd35);

        // Full-depth delay with coincident strobe.
        load(32, 1'b1);
        check("t2 ch0 D=32",   64'(data_out[W-1:0]), 64'd9);
        check("t2 valid D=32", 64'(out_valid), 64'd1);
        check("t2 cur D=32",   64'(cur_delay), 64'd32);
        strobe(1);
        check("t2 ch0 next",   64'(data_out[W-1:0]), 64'd10);

        // Clamping.
        load(0, 1'b0);
        check("t3 cur 0->1",    64'(cur_delay), 64'd1);
        check("t3 clamped lo",  64'(delay_clamped), 64'd1);
        check("t3 hold ch0",    64'(data_out[W-1:0]), 64'd10);
        load(63, 1'b0);
        check("t3 cur 63->32",  64'(cur_delay), 64'd32);
        check("t3 clamped hi",  64'(delay_clamped), 64'd1);
        load(10, 1'b0);
        check("t3 cur 10",      64'(cur_delay), 64'd10);
        check("t3 clamped clr", 64'(delay_clamped), 64'd0);

        // Delay counted in strobes with en gaps.
        load(3, 1'b1);
        check("t4 ch0 s43", 64'(data_out[W-1:0]), 64'd40);
        tick();
        tick();
        check("t4 hold ch0",   64'(data_out[W-1:0]), 64'd40);
        check("t4 hold valid", 64'(out_valid), 64'd1);
        strobe(1);
        check("t4 ch0 s44", 64'(data_out[W-1:0]), 64'd41);
        tick();
        strobe(1);
        check("t4 ch0 s45", 64'(data_out[W-1:0]), 64'd42);

        // Flush at strobe 50 with D=8; the coincident strobe is discarded.
        load(8, 1'b0);
        strobe(4);
        samp++;
        data_in = pack(samp);
        en      = 1'b1;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        en      = 1'b0;
        check("t5 flush data",  64'(data_out), 64'd0);
        check("t5 flush valid", 64'(out_valid), 64'd0);
        strobe(8);
        check("t5 valid after 8", 64'(out_valid), 64'd0);
        check("t5 blank after 8", 64'(data_out), 64'd0);
        strobe(1);
        check("t5 valid after 9", 64'(out_valid), 64'd1);
        check("t5 ch0 after 9",   64'(data_out[W-1:0]), 64'd51);

        // Mid-cycle async reset, then load+strobe in the same cycle.
        load(0, 1'b0);
        strobe(3);
        #2 rstn = 1'b0;
        #1;
        check("t6 rst data",    64'(data_out), 64'd0);
        check("t6 rst valid",   64'(out_valid), 64'd0);
        check("t6 rst cur",     64'(cur_delay), 64'd5);
        check("t6 rst clamped", 64'(delay_clamped), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        strobe(3);
        load(2, 1'b1);
        check("t6 load+en ch0",   64'(data_out[W-1:0]), 64'(samp - 2));
        check("t6 load+en valid", 64'(out_valid), 64'd1);
        check("t6 load+en cur",   64'(cur_delay), 64'd2);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
